// File: rtl/pbuff_window_reader_pkg.sv
// Shared geometry of the partial column buffer and read-side state encoding.
// Window width is exported for the kernel side.
package pbuff_window_reader_pkg;

    localparam int hwidth       = 640;
    localparam int awidth_pbuff = 10;
    localparam int dwidth_dat   = 12;
    localparam int dwidth_slice = 3;
    localparam int win_width    = 3 * dwidth_dat * dwidth_slice;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRIME,
        ST_FILL,
        ST_STREAM
    } rd_state_e;

    // Saturating increment: the right border re-reads the last column.
    function automatic int sat_inc(input int addr, input int last);
        return (addr >= last) ? last : addr + 1;
    endfunction

endpackage

// File: rtl/pbuff_col_shreg.sv
// Three-stage column shift register holding {right, centre, left}.
// load_all fills every stage with one column so the left border is replicated.
module pbuff_col_shreg
    import pbuff_window_reader_pkg::*;
#(
    parameter int CWIDTH = dwidth_dat * dwidth_slice
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_all,
    input  logic                shift_en,
    input  logic [CWIDTH-1:0]   din,
    output logic [3*CWIDTH-1:0] win
);

    logic [CWIDTH-1:0] r2;
    logic [CWIDTH-1:0] r1;
    logic [CWIDTH-1:0] r0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r2 <= '0;
            r1 <= '0;
            r0 <= '0;
        end else if (load_all) begin
            r2 <= din;
            r1 <= din;
            r0 <= din;
        end else if (shift_en) begin
            r0 <= r1;
            r1 <= r2;
            r2 <= din;
        end
    end

    assign win = {r2, r1, r0};

endmodule

// File: rtl/pbuff_window_reader.sv
// Read-side sequencer for the partial column buffer: scans one committed row
// and streams edge-replicated 3-column windows over a valid/ready handshake.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for start; raddr parked at 0
// ST_PRIME  | column 0 on rdata, loaded into all three window stages
// ST_FILL   | column 1 on rdata, shifted in; first window becomes valid
// ST_STREAM | one window per handshake; last column ends the row
module pbuff_window_reader
    import pbuff_window_reader_pkg::*;
#(
    parameter int HWIDTH = hwidth,
    parameter int AWIDTH = awidth_pbuff,
    parameter int DWIDTH = dwidth_dat,
    parameter int SLICE  = dwidth_slice
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       busy,
    output logic [AWIDTH-1:0]          raddr,
    input  logic [DWIDTH*SLICE-1:0]    rdata,
    output logic                       win_valid,
    input  logic                       win_ready,
    output logic [3*DWIDTH*SLICE-1:0]  win_data,
    output logic [AWIDTH-1:0]          win_col,
    output logic                       done
);

    localparam logic [AWIDTH-1:0] LAST_COL = AWIDTH'(HWIDTH - 1);

    rd_state_e         state;
    logic              handshake;
    logic              load_all;
    logic              shift_en;
    logic [AWIDTH-1:0] raddr_next;

    always_comb begin
        handshake  = win_valid && win_ready;
        load_all   = (state == ST_PRIME);
        // The final window needs no new column, so it never shifts.
        shift_en   = (state == ST_FILL) ||
                     ((state == ST_STREAM) && handshake && (win_col != LAST_COL));
        raddr_next = AWIDTH'(sat_inc(int'(raddr), HWIDTH - 1));
    end

    pbuff_col_shreg #(
        .CWIDTH (DWIDTH * SLICE)
    ) u_col_shreg (
        .clk      (clk),
        .rst      (rst),
        .load_all (load_all),
        .shift_en (shift_en),
        .din      (rdata),
        .win      (win_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            raddr     <= '0;
            win_valid <= 1'b0;
            win_col   <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_PRIME;
                        raddr <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_PRIME: begin
                    raddr <= raddr_next;
                    state <= ST_FILL;
                end
                ST_FILL: begin
                    raddr     <= raddr_next;
                    win_col   <= '0;
                    win_valid <= 1'b1;
                    state     <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (handshake) begin
                        if (win_col == LAST_COL) begin
                            win_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            win_col <= win_col + AWIDTH'(1);
                            raddr   <= raddr_next;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pbuff_window_reader.sv
// Bench for pbuff_window_reader: full-width and 4-column instances checked
// against an array-based window model with edge replication.
module tb_pbuff_window_reader;

    localparam int HW = 640;
    localparam int AW = 10;
    localparam int CW = 36;
    localparam int WW = 108;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic win_ready = 1'b0;
    logic start_s = 1'b0;
    logic win_ready_s = 1'b0;

    logic          busy, win_valid, done;
    logic [AW-1:0] raddr, win_col;
    logic [CW-1:0] rdata;
    logic [WW-1:0] win_data;

    logic          busy_s, win_valid_s, done_s;
    logic [1:0]    raddr_s, win_col_s;
    logic [CW-1:0] rdata_s;
    logic [WW-1:0] win_data_s;

    logic [CW-1:0] mem   [0:1023];
    logic [CW-1:0] mem_s [0:3];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    assign rdata   = mem[raddr];
    assign rdata_s = mem_s[raddr_s];

    pbuff_window_reader dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .raddr(raddr),
        .rdata(rdata), .win_valid(win_valid), .win_ready(win_ready),
        .win_data(win_data), .win_col(win_col), .done(done)
    );

    pbuff_window_reader #(.HWIDTH(4), .AWIDTH(2)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .busy(busy_s), .raddr(raddr_s),
        .rdata(rdata_s), .win_valid(win_valid_s), .win_ready(win_ready_s),
        .win_data(win_data_s), .win_col(win_col_s), .done(done_s)
    );

    function automatic logic [CW-1:0] col_of(input int x);
        logic [11:0] p;
        p = 12'(x);
        return {p, p, p};
    endfunction

    function automatic logic [WW-1:0] pix3(input int a, input int b, input int c);
        return {col_of(a), col_of(b), col_of(c)};
    endfunction

    // Reference window: right/left neighbours clamp to the row borders.
    function automatic logic [WW-1:0] exp_win(input int c);
        int l;
        int r;
        l = (c == 0) ? 0 : c - 1;
        r = (c == HW - 1) ? c : c + 1;
        return {mem[r], mem[c], mem[l]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 1024; i++) mem[i] = col_of(i);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if ({busy, win_valid, done} !== 3'b000) $display("FAIL reset_flags got=%b exp=000", {busy, win_valid, done}); else n_pass++;
        n_checks++; if (raddr !== '0 || win_col !== '0) $display("FAIL reset_addr raddr=%0d win_col=%0d exp=0", raddr, win_col); else n_pass++;
        n_checks++; if (win_data !== '0) $display("FAIL reset_data got=%h exp=0", win_data); else n_pass++;
        n_checks++; if ({busy_s, win_valid_s, done_s, raddr_s, win_col_s} !== 7'b0 || win_data_s !== '0) $display("FAIL reset_small got=%b exp=0", {busy_s, win_valid_s, done_s, raddr_s, win_col_s}); else n_pass++;
        #2 rst = 1'b1;
    endtask

    task automatic test_ramp();
        int col_exp = 0;
        int cyc = 0;
        int first_valid = -1;
        int done_cyc = -1;
        int max_raddr = 0;
        logic [WW-1:0] lit;
        load_ramp();
        win_ready = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        while (done_cyc < 0 && cyc < 2000) begin
            step(); cyc++;
            if (int'(raddr) > max_raddr) max_raddr = int'(raddr);
            if (done) done_cyc = cyc;
            if (win_valid) begin
                if (first_valid < 0) first_valid = cyc;
                n_checks++; if (win_col !== AW'(col_exp) || win_data !== exp_win(col_exp)) $display("FAIL ramp_window col=%0d got_col=%0d got=%h exp=%h", col_exp, win_col, win_data, exp_win(col_exp)); else n_pass++;
                if (col_exp == 0 || col_exp == 5 || col_exp == HW - 1) begin
                    lit = (col_exp == 0) ? pix3(1, 0, 0) : (col_exp == 5) ? pix3(6, 5, 4) : pix3(639, 639, 638);
                    n_checks++; if (win_data !== lit) $display("FAIL ramp_border col=%0d got=%h exp=%h", col_exp, win_data, lit); else n_pass++;
                end
                col_exp++;
            end
        end
        n_checks++; if (first_valid !== 2) $display("FAIL ramp_latency got=%0d exp=2", first_valid); else n_pass++;
        n_checks++; if (done_cyc !== 642) $display("FAIL ramp_done_cycle got=%0d exp=642", done_cyc); else n_pass++;
        n_checks++; if (col_exp !== HW) $display("FAIL ramp_count got=%0d exp=%0d", col_exp, HW); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL ramp_busy_at_done got=%b exp=0", busy); else n_pass++;
        n_checks++; if (max_raddr !== HW - 1) $display("FAIL ramp_raddr_max got=%0d exp=%0d", max_raddr, HW - 1); else n_pass++;
        step();
        n_checks++; if (done !== 1'b0) $display("FAIL ramp_done_width got=%b exp=0", done); else n_pass++;
    endtask

    task automatic test_backpressure();
        int col_exp = 0;
        int cyc = 0;
        logic stalled = 1'b0;
        win_ready = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        while (!done && cyc < 2000) begin
            step(); cyc++;
            if (win_valid) begin
                if (win_col == 100 && !stalled) begin
                    stalled = 1'b1;
                    win_ready = 1'b0;
                    repeat (5) begin
                        step(); cyc++;
                        n_checks++; if (win_data !== pix3(101, 100, 99) || win_col !== AW'(100) || raddr !== AW'(102) || !win_valid) $display("FAIL bp_hold col=%0d raddr=%0d got=%h exp=%h", win_col, raddr, win_data, pix3(101, 100, 99)); else n_pass++;
                    end
                    win_ready = 1'b1;
                end
                n_checks++; if (win_col !== AW'(col_exp) || win_data !== exp_win(col_exp)) $display("FAIL bp_window col=%0d got_col=%0d got=%h exp=%h", col_exp, win_col, win_data, exp_win(col_exp)); else n_pass++;
                if (col_exp == 101) begin
                    n_checks++; if (win_data !== pix3(102, 101, 100)) $display("FAIL bp_release got=%h exp=%h", win_data, pix3(102, 101, 100)); else n_pass++;
                end
                col_exp++;
            end
        end
        n_checks++; if (col_exp !== HW || !done || !stalled) $display("FAIL bp_count got=%0d exp=%0d done=%b", col_exp, HW, done); else n_pass++;
    endtask

    task automatic test_start_during_scan();
        int col_exp = 0;
        int cyc = 0;
        logic fired = 1'b0;
        win_ready = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        while (!done && cyc < 2000) begin
            step(); cyc++;
            start = 1'b0;
            if (win_valid) begin
                n_checks++; if (win_col !== AW'(col_exp) || win_data !== exp_win(col_exp)) $display("FAIL sds_window col=%0d got_col=%0d got=%h exp=%h", col_exp, win_col, win_data, exp_win(col_exp)); else n_pass++;
                if (col_exp == 50 && !fired) begin
                    start = 1'b1;
                    fired = 1'b1;
                end
                col_exp++;
            end
        end
        n_checks++; if (col_exp !== HW || !done || busy) $display("FAIL sds_ignored count=%0d exp=%0d done=%b busy=%b", col_exp, HW, done, busy); else n_pass++;
        start = 1'b1; step(); start = 1'b0;
        n_checks++; if (busy !== 1'b1 || done !== 1'b0 || win_valid !== 1'b0) $display("FAIL sds_restart busy=%b done=%b valid=%b exp=100", busy, done, win_valid); else n_pass++;
        step(); step();
        n_checks++; if (win_valid !== 1'b1 || win_col !== '0 || win_data !== pix3(1, 0, 0)) $display("FAIL sds_first valid=%b col=%0d got=%h exp=%h", win_valid, win_col, win_data, pix3(1, 0, 0)); else n_pass++;
        for (int i = 0; i < 2000 && !done; i++) step();
        n_checks++; if (done !== 1'b1) $display("FAIL sds_drain done=%b exp=1", done); else n_pass++;
    endtask

    task automatic test_reset_mid();
        win_ready = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 1000 && !(win_valid && win_col == 300); i++) step();
        n_checks++; if (!(win_valid && win_col == 300)) $display("FAIL rm_reach col=%0d exp=300", win_col); else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_checks++; if ({busy, win_valid, done} !== 3'b000 || raddr !== '0 || win_col !== '0) $display("FAIL rm_state flags=%b raddr=%0d col=%0d exp=0", {busy, win_valid, done}, raddr, win_col); else n_pass++;
        n_checks++; if (win_data !== '0) $display("FAIL rm_data got=%h exp=0", win_data); else n_pass++;
        #2 rst = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        step(); step();
        n_checks++; if (win_valid !== 1'b1 || win_col !== '0 || win_data !== pix3(1, 0, 0)) $display("FAIL rm_restart valid=%b col=%0d got=%h exp=%h", win_valid, win_col, win_data, pix3(1, 0, 0)); else n_pass++;
        for (int i = 0; i < 2000 && !done; i++) step();
        n_checks++; if (done !== 1'b1) $display("FAIL rm_drain done=%b exp=1", done); else n_pass++;
    endtask

    task automatic test_small();
        logic [WW-1:0] exp_s [0:3];
        int n = 0;
        int cyc = 0;
        int max_raddr = 0;
        exp_s[0] = pix3(1, 0, 0);
        exp_s[1] = pix3(2, 1, 0);
        exp_s[2] = pix3(3, 2, 1);
        exp_s[3] = pix3(3, 3, 2);
        for (int i = 0; i < 4; i++) mem_s[i] = col_of(i);
        win_ready_s = 1'b1;
        start_s = 1'b1; step(); start_s = 1'b0;
        while (!done_s && cyc < 50) begin
            step(); cyc++;
            if (int'(raddr_s) > max_raddr) max_raddr = int'(raddr_s);
            if (win_valid_s) begin
                if (n < 4) begin
                    n_checks++; if (win_data_s !== exp_s[n] || win_col_s !== 2'(n)) $display("FAIL small_window n=%0d col=%0d got=%h exp=%h", n, win_col_s, win_data_s, exp_s[n]); else n_pass++;
                end
                n++;
            end
        end
        n_checks++; if (n !== 4 || !done_s) $display("FAIL small_count got=%0d exp=4 done=%b", n, done_s); else n_pass++;
        n_checks++; if (max_raddr !== 3) $display("FAIL small_raddr_max got=%0d exp=3", max_raddr); else n_pass++;
    endtask

    task automatic test_random_ready();
        for (int row = 0; row < 10; row++) begin
            int col_exp = 0;
            int cyc = 0;
            logic stall = 1'b0;
            logic [WW-1:0] prev_data = '0;
            logic [AW-1:0] prev_col = '0;
            logic [AW-1:0] prev_raddr = '0;
            for (int i = 0; i < HW; i++) mem[i] = CW'({$urandom(), $urandom()});
            win_ready = 1'(($urandom() >> 3) & 1);
            start = 1'b1; step(); start = 1'b0;
            while (!done && cyc < 8000) begin
                step(); cyc++;
                if (stall) begin
                    n_checks++; if (win_data !== prev_data || win_col !== prev_col || raddr !== prev_raddr || !win_valid) $display("FAIL rnd_hold row=%0d col=%0d got=%h exp=%h", row, win_col, win_data, prev_data); else n_pass++;
                end
                win_ready = 1'(($urandom() >> 5) & 1);
                if (win_valid && win_ready) begin
                    n_checks++; if (win_col !== AW'(col_exp) || win_data !== exp_win(col_exp)) $display("FAIL rnd_window row=%0d col=%0d got_col=%0d got=%h exp=%h", row, col_exp, win_col, win_data, exp_win(col_exp)); else n_pass++;
                    col_exp++;
                end
                stall = win_valid && !win_ready;
                prev_data = win_data;
                prev_col = win_col;
                prev_raddr = raddr;
            end
            n_checks++; if (col_exp !== HW || !done || busy) $display("FAIL rnd_row row=%0d count=%0d exp=%0d done=%b busy=%b", row, col_exp, HW, done, busy); else n_pass++;
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        for (int i = 0; i < 4; i++) mem_s[i] = '0;
        test_reset();
        test_ramp();
        test_backpressure();
        test_start_during_scan();
        test_reset_mid();
        test_small();
        test_random_ready();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pbuff_window_reader.md
# pbuff_window_reader

Read-side sequencer for the partial column buffer. After the writer commits a row of column slices with `pop`, this block scans column addresses 0..HWIDTH-1 on the buffer's read port. It assembles a 3-column sliding window (edge-replicated at both borders) and streams one window per column to the downstream kernel over a valid/ready handshake. It sits between the partial buffer and the filter datapath.

## Interface
- HWIDTH, 640, columns per row (`hwidth`)
- AWIDTH, 10, column address width (`awidth_pbuff`)
- DWIDTH, 12, pixel width, RGB444 (`dwidth_dat`)
- SLICE, 3, pixels per column slice (`dwidth_slice`)
- clk  in  1  sole clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse: the buffer holds a committed row, begin a scan
- busy  out  1  high from accepted start until the last window handshakes; the writer must not `pop` while high
- raddr  out  AWIDTH  column address to the buffer read port
- rdata  in  DWIDTH*SLICE  column at `raddr`, combinational from the buffer
- win_valid  out  1  window valid
- win_ready  in  1  downstream accepts
- win_data  out  3*DWIDTH*SLICE  {col c+1, col c, col c-1}, each column in buffer order {RGB_N..RGB_1}
- win_col  out  AWIDTH  centre column c of the current window
- done  out  1  one-cycle pulse after the final window handshakes

## Operation
- Registers: three column registers R2 (right), R1 (centre), R0 (left); `raddr`; `win_col`; FSM.
- FSM states:
  - IDLE: `start` → PRIME, `raddr` ← 0, `busy` ← 1.
  - PRIME: R1, R0 ← rdata (col 0). `raddr` ← 1. Go to FILL.
  - FILL: R2 ← rdata (col 1). `raddr` ← 2. `win_col` ← 0. `win_valid` ← 1. Go to STREAM.
  - STREAM: on `win_valid && win_ready`:
    - If `win_col` = HWIDTH-1: `win_valid` ← 0, `busy` ← 0, `done` ← 1, go to IDLE.
    - Otherwise: shift (R0 ← R1, R1 ← R2, R2 ← rdata), `win_col` ← `win_col`+1, `raddr` ← min(`raddr`+1, HWIDTH-1).
- Border rule: the window for col 0 is {1,0,0}; the window for col HWIDTH-1 is {H-1,H-1,H-2}. The right edge comes from `raddr` saturation, so the last column is re-read.
- `start` outside IDLE is ignored. `start` in the `done` cycle is accepted, because the FSM is already in IDLE.
- HWIDTH ≥ 2 is required.
- Address arithmetic is AWIDTH wide. The saturation compare is against HWIDTH-1, so `raddr` never reaches HWIDTH.

## Timing
- Reset values: `busy`=0, `raddr`=0, `win_valid`=0, `win_data`=0, `win_col`=0, `done`=0, FSM=IDLE.
- Latency: `start` sampled at edge T0 gives `win_valid` high after edge T2.
- Throughput: 1 window/cycle while `win_ready`=1. A full row takes HWIDTH+2 cycles from `start` to `done`.
- `rdata` is sampled on the same edge that `raddr` is presented. `raddr` is registered, so the path is `raddr` reg → buffer mux → R2.
- Backpressure: with `win_valid`=1 and `win_ready`=0, `win_data`, `win_col` and `raddr` hold and nothing shifts. The window is AXI-style: once asserted, it is not withdrawn until the handshake.
- `done` is high for exactly one cycle, coincident with `busy` falling.
- Reset mid-scan clears all state immediately. The next `start` begins at col 0 and has no memory of the aborted row.

## Structure
- HWIDTH, AWIDTH, DWIDTH and SLICE defaults come from the shared `my_header.vh` macros. No new globals are added.
- Add `win_width` = 3*`dwidth_dat`*`dwidth_slice` to the header for kernel-side use.
- One natural sub-module, `pbuff_col_shreg`: the 3-stage column shift register with load-all (PRIME) and shift-enable.
- The FSM and counters stay in the top module.

## Test plan
- **Ramp, ready=1.** Buffer column i holds all pixels = i, then pulse `start`. Expect:
  - 640 windows on consecutive cycles, the first 2 cycles after `start`;
  - col 0 = {1,0,0}, col 5 = {6,5,4}, col 639 = {639,639,638};
  - `done` 642 cycles after `start`.
- **Backpressure.** Hold `win_ready`=0 for 5 cycles at `win_col`=100. Expect `win_data`={101,100,99} and `raddr`=102 stable throughout. On release, col 101 = {102,101,100}, with no skipped or duplicated columns.
- **Start during scan.** Pulse `start` at `win_col`=50, then pulse it again in the `done` cycle. Expect the first pulse to be ignored and the second to start a new scan beginning at col 0.
- **Reset mid-scan.** Assert `rst`=0 asynchronously at `win_col`=300. Expect all outputs at reset values before the next edge. A later `start` gives col 0 = {1,0,0}.
- **HWIDTH=4 instance.** Expect exactly the windows {1,0,0}, {2,1,0}, {3,2,1}, {3,3,2}, and `raddr` never exceeding 3.
- **Random `win_ready`.** Toggle `win_ready` randomly over 10 rows. Scoreboard against a reference model: every column appears exactly once, in order, with correct edge replication.
